pe_noc_l2_sched: RTL and testbench
==================================

# pe_noc_l2_sched

Weighted round-robin admission scheduler that shares the single L2 data port of the PE NoC among the cluster requesters. It bounds each cluster's outstanding L2 transactions with a credit counter and issues one registered grant per cycle toward the L2 data path. Completions returning from L2 release the credits.

## Interface

**Parameters**
- `NumReq`, 4: number of requesters (clusters); must be ≥ 2.
- `CntWidth`, 4: width of each outstanding-transaction counter and of `max_outst_i`.
- `WeightWidth`, 4: width of each per-requester weight.
- `IdxWidth`, `$clog2(NumReq)`: derived; do not override.

**Ports**
- `clk_i`, input, 1: clock.
- `rst_i`, input, 1: reset. Synchronous, active-high.
- `req_valid_i`, input, `NumReq`: requester i has a pending L2 transaction.
- `req_write_i`, input, `NumReq`: request type per requester (1 = write, 0 = read).
- `req_ready_o`, output, `NumReq`: one-hot or zero. Requester i's request is accepted this cycle.
- `weight_i`, input, `NumReq` × `WeightWidth`: grants per turn. A value of 0 is treated as 1.
- `max_outst_i`, input, `CntWidth`: credit limit applied to every requester.
- `gnt_valid_o`, output, 1: a registered grant is presented.
- `gnt_ready_i`, input, 1: downstream accepts the grant.
- `gnt_idx_o`, output, `IdxWidth`: index of the granted requester.
- `gnt_write_o`, output, 1: type of the granted request.
- `cpl_valid_i`, input, 1: one L2 transaction has completed.
- `cpl_idx_i`, input, `IdxWidth`: requester that owns the completion.
- `outst_o`, output, `NumReq` × `CntWidth`: current outstanding count per requester.
- `err_o`, output, 1: sticky flag for a completion that arrived with no credit in use.

## Operation

**Eligibility**
- Requester i is eligible when `req_valid_i[i]` is set and `outst[i] < max_outst_i`.
- If `max_outst_i` is 0, no requester is eligible.

**Load condition**
- The output register loads a new grant when it is empty or being drained: `load = !gnt_valid_o || gnt_ready_i`.

**Selection (only when `load` is true)**
- Stay with the current owner `cur` if it is still eligible and `quantum > 0`. On staying, `quantum` decrements.
- Otherwise, pick the first eligible index in order `cur+1, cur+2, …`, wrapping modulo `NumReq`, with `cur` itself checked last.
- On a switch to winner w: set `cur = w` and `quantum = max(weight_i[w], 1) - 1`.
- If nothing is eligible, the register empties (`gnt_valid_o` = 0). `cur` and `quantum` are unchanged.

**Acceptance**
- In the same cycle as the selection, `req_ready_o[w]` = 1. The register captures `gnt_idx_o = w` and `gnt_write_o = req_write_i[w]`.
- The accepted requester's credit counter increments in that cycle.

**Completion**
- `cpl_valid_i` decrements `outst[cpl_idx_i]`.
- An increment and a decrement on the same index in the same cycle leave the counter unchanged.
- A decrement at 0 saturates at 0 and sets `err_o`. `err_o` clears only on reset.
- An increment never exceeds the limit, because eligibility requires `outst < max_outst_i`.

**Limit changes**
- If `max_outst_i` is lowered below a current count, existing credits are kept. The requester stays ineligible until its count drops below the new limit.

## Timing

**Reset values**
- `gnt_valid_o` = 0, `gnt_idx_o` = 0, `gnt_write_o` = 0, `req_ready_o` = 0.
- All `outst` counters = 0, `err_o` = 0.
- `cur = NumReq-1`, so requester 0 wins first. `quantum` = 0.

**Reset during operation**
- A reset asserted mid-operation drops a pending grant without handshake and clears all credits.
- The environment must also reset the L2 path.

**Latency and throughput**
- Request to grant: 1 cycle (`req_ready_o` in cycle t, `gnt_valid_o` in cycle t+1).
- Throughput is 1 grant per cycle while `gnt_ready_i` is held high.
- `req_ready_o` depends combinationally on `req_valid_i`, on the counters and on `gnt_ready_i`. It has no dependency on `cpl_valid_i`: a completion frees a credit from the following cycle onward.

**Handshake rules**
- While `gnt_valid_o && !gnt_ready_i`, `gnt_idx_o` and `gnt_write_o` stay stable and all `req_ready_o` bits are 0.
- Requesters must hold `req_valid_i` and `req_write_i` stable until their `req_ready_o` is seen.

## Structure

**Shared package `pe_noc_pkg`**
- Holds the default values of `CntWidth` and `WeightWidth`.
- Holds the credit-counter type `outst_cnt_t`.

**Sub-module `rr_next_idx`**
- Combinational wrap-around priority finder.
- Inputs: eligibility vector and `cur`. Outputs: `found` and `idx`.
- Implemented as a doubled-vector leading-one search.

**Top level**
- Contains the output register, `cur` and `quantum` state, the credit counter array and `err_o`.

## Test plan

1. **Round-robin fairness:** reset; all four requesters valid, weights 1, `max_outst_i` = 15, `gnt_ready_i` = 1. Required: grants 0,1,2,3,0,… on consecutive cycles, first grant in cycle 1 after reset release.
2. **Weights:** `weight_i` = {1,1,1,3} (indices 3..0), all requesters valid. Required: sequence 0,0,0,1,2,3,0,0,0,…
3. **Credit limit:** `max_outst_i` = 2, only requester 2 valid, no completions. Required: exactly 2 grants, then `req_ready_o[2]` stays 0. One `cpl_valid_i` with idx 2 gives one more grant, starting the cycle after the completion.
4. **Backpressure:** hold `gnt_ready_i` = 0 for 5 cycles with the grant pending. Required: `gnt_idx_o` stable, no `req_ready_o`, counters unchanged; resumes at full rate once ready returns.
5. **Simultaneous increment/decrement and underflow:** requester 1 is accepted while `cpl_idx_i` = 1 in the same cycle. Required: `outst_o[1]` unchanged. A completion to idx 3 while `outst_o[3]` = 0 gives `outst_o[3]` = 0 and `err_o` = 1, held until reset.
6. **Mid-operation reset:** assert `rst_i` for 1 cycle with a grant pending and counters nonzero. Required: next cycle all outputs at their reset values, and requester 0 wins first.

Source files
------------

// File: rtl/pe_noc_pkg.sv
// rtl/pe_noc_pkg.sv - shared widths and types for the PE NoC L2 scheduler
package pe_noc_pkg;

    localparam int unsigned CntWidthDef    = 4;
    localparam int unsigned WeightWidthDef = 4;

    typedef logic [CntWidthDef-1:0] outst_cnt_t;

endpackage

// File: rtl/rr_next_idx.sv
// rtl/rr_next_idx.sv - wrap-around priority finder starting after cur_i
module rr_next_idx #(
    parameter int unsigned NumReq   = 4,
    parameter int unsigned IdxWidth = $clog2(NumReq)
) (
    input  logic [NumReq-1:0]   elig_i,
    input  logic [IdxWidth-1:0] cur_i,
    output logic                found_o,
    output logic [IdxWidth-1:0] idx_o
);

    logic [2*NumReq-1:0] dbl;
    logic [NumReq-1:0]   rot;
    logic [IdxWidth:0]   shamt;
    int                  off;
    int                  pos;

    // Window starting at cur+1 of the doubled vector; cur itself lands in the top bit.
    assign dbl   = {elig_i, elig_i};
    assign shamt = {1'b0, cur_i} + 1'b1;
    assign rot   = dbl[shamt +: NumReq];

    always_comb begin
        found_o = 1'b0;
        off     = 0;
        pos     = 0;
        for (int i = int'(NumReq) - 1; i >= 0; i--) begin
            if (rot[i]) begin
                found_o = 1'b1;
                off     = i;
            end
        end
        pos = int'(cur_i) + 1 + off;
        if (pos >= int'(NumReq)) begin
            pos = pos - int'(NumReq);
        end
        idx_o = IdxWidth'(pos);
    end

endmodule

// File: rtl/pe_noc_l2_sched.sv
// rtl/pe_noc_l2_sched.sv - weighted round-robin L2 admission scheduler with per-cluster credits
module pe_noc_l2_sched
    import pe_noc_pkg::*;
#(
    parameter int unsigned NumReq      = 4,
    parameter int unsigned CntWidth    = CntWidthDef,
    parameter int unsigned WeightWidth = WeightWidthDef,
    parameter int unsigned IdxWidth    = $clog2(NumReq)
) (
    input  logic                                 clk_i,
    input  logic                                 rst_i,
    input  logic [NumReq-1:0]                    req_valid_i,
    input  logic [NumReq-1:0]                    req_write_i,
    output logic [NumReq-1:0]                    req_ready_o,
    input  logic [NumReq-1:0][WeightWidth-1:0]   weight_i,
    input  logic [CntWidth-1:0]                  max_outst_i,
    output logic                                 gnt_valid_o,
    input  logic                                 gnt_ready_i,
    output logic [IdxWidth-1:0]                  gnt_idx_o,
    output logic                                 gnt_write_o,
    input  logic                                 cpl_valid_i,
    input  logic [IdxWidth-1:0]                  cpl_idx_i,
    output logic [NumReq-1:0][CntWidth-1:0]      outst_o,
    output logic                                 err_o
);

    logic                             gnt_valid_q, gnt_valid_d;
    logic [IdxWidth-1:0]              gnt_idx_q, gnt_idx_d;
    logic                             gnt_write_q, gnt_write_d;
    logic [IdxWidth-1:0]              cur_q, cur_d;
    logic [WeightWidth-1:0]           quantum_q, quantum_d;
    logic [NumReq-1:0][CntWidth-1:0]  outst_q, outst_d;
    logic                             err_q, err_d;

    logic [NumReq-1:0]   elig;
    logic                load;
    logic                accept;
    logic [IdxWidth-1:0] sel_idx;
    logic                rr_found;
    logic [IdxWidth-1:0] rr_idx;
    logic                underflow;

    always_comb begin
        for (int i = 0; i < int'(NumReq); i++) begin
            elig[i] = req_valid_i[i] && (outst_q[i] < max_outst_i);
        end
    end

    assign load = !gnt_valid_q || gnt_ready_i;

    rr_next_idx #(
        .NumReq   (NumReq),
        .IdxWidth (IdxWidth)
    ) u_rr_next_idx (
        .elig_i  (elig),
        .cur_i   (cur_q),
        .found_o (rr_found),
        .idx_o   (rr_idx)
    );

    always_comb begin
        accept      = 1'b0;
        sel_idx     = cur_q;
        cur_d       = cur_q;
        quantum_d   = quantum_q;
        gnt_valid_d = gnt_valid_q;
        gnt_idx_d   = gnt_idx_q;
        gnt_write_d = gnt_write_q;
        if (load) begin
            if (elig[cur_q] && (quantum_q != '0)) begin
                accept    = 1'b1;
                sel_idx   = cur_q;
                quantum_d = quantum_q - 1'b1;
            end else if (rr_found) begin
                accept    = 1'b1;
                sel_idx   = rr_idx;
                cur_d     = rr_idx;
                // A zero weight still earns one grant per turn.
                quantum_d = (weight_i[rr_idx] == '0) ? '0 : weight_i[rr_idx] - 1'b1;
            end
            gnt_valid_d = accept;
            if (accept) begin
                gnt_idx_d   = sel_idx;
                gnt_write_d = req_write_i[sel_idx];
            end
        end
    end

    always_comb begin
        req_ready_o = '0;
        if (accept && !rst_i) begin
            req_ready_o[sel_idx] = 1'b1;
        end
    end

    always_comb begin
        underflow = 1'b0;
        outst_d   = outst_q;
        for (int i = 0; i < int'(NumReq); i++) begin
            if (accept && (sel_idx == IdxWidth'(i)) &&
                !(cpl_valid_i && (cpl_idx_i == IdxWidth'(i)))) begin
                outst_d[i] = outst_q[i] + 1'b1;
            end else if (cpl_valid_i && (cpl_idx_i == IdxWidth'(i)) &&
                         !(accept && (sel_idx == IdxWidth'(i)))) begin
                if (outst_q[i] == '0) begin
                    underflow = 1'b1;
                end else begin
                    outst_d[i] = outst_q[i] - 1'b1;
                end
            end
        end
        err_d = err_q || underflow;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            gnt_valid_q <= 1'b0;
            gnt_idx_q   <= '0;
            gnt_write_q <= 1'b0;
            cur_q       <= IdxWidth'(NumReq - 1);
            quantum_q   <= '0;
            outst_q     <= '0;
            err_q       <= 1'b0;
        end else begin
            gnt_valid_q <= gnt_valid_d;
            gnt_idx_q   <= gnt_idx_d;
            gnt_write_q <= gnt_write_d;
            cur_q       <= cur_d;
            quantum_q   <= quantum_d;
            outst_q     <= outst_d;
            err_q       <= err_d;
        end
    end

    assign gnt_valid_o = gnt_valid_q;
    assign gnt_idx_o   = gnt_idx_q;
    assign gnt_write_o = gnt_write_q;
    assign outst_o     = outst_q;
    assign err_o       = err_q;

endmodule

// File: tb/tb_pe_noc_l2_sched.sv
// tb/tb_pe_noc_l2_sched.sv - directed self-checking bench for pe_noc_l2_sched
module tb_pe_noc_l2_sched;
    import pe_noc_pkg::*;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [3:0]       req_valid = '0;
    logic [3:0]       req_write = '0;
    logic [3:0]       req_ready;
    logic [3:0][3:0]  weight = '0;
    logic [3:0]       max_outst = '0;
    logic             gnt_valid;
    logic             gnt_ready = 1'b0;
    logic [1:0]       gnt_idx;
    logic             gnt_write;
    logic             cpl_valid = 1'b0;
    logic [1:0]       cpl_idx = '0;
    logic [3:0][3:0]  outst;
    logic             err;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    pe_noc_l2_sched #(
        .NumReq      (4),
        .CntWidth    (4),
        .WeightWidth (4)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .req_valid_i (req_valid),
        .req_write_i (req_write),
        .req_ready_o (req_ready),
        .weight_i    (weight),
        .max_outst_i (max_outst),
        .gnt_valid_o (gnt_valid),
        .gnt_ready_i (gnt_ready),
        .gnt_idx_o   (gnt_idx),
        .gnt_write_o (gnt_write),
        .cpl_valid_i (cpl_valid),
        .cpl_idx_i   (cpl_idx),
        .outst_o     (outst),
        .err_o       (err)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        req_valid = '0;
        cpl_valid = 1'b0;
        rst       = 1'b1;
        tick();
        rst       = 1'b0;
    endtask

    int         seq_idx [10] = '{0, 0, 0, 1, 2, 3, 0, 0, 0, 1};
    outst_cnt_t exp_cnt;

    initial begin
        // Reset state
        repeat (2) tick();
        check_eq("rst_gnt_valid", 32'(gnt_valid), 0);
        check_eq("rst_gnt_idx", 32'(gnt_idx), 0);
        check_eq("rst_gnt_write", 32'(gnt_write), 0);
        check_eq("rst_req_ready", 32'(req_ready), 0);
        check_eq("rst_outst", 32'(outst), 0);
        check_eq("rst_err", 32'(err), 0);

        // Round-robin fairness
        rst       = 1'b0;
        weight    = {4'd1, 4'd1, 4'd1, 4'd1};
        max_outst = 4'd15;
        gnt_ready = 1'b1;
        req_valid = 4'hF;
        #1;
        check_eq("rr_ready_c0", 32'(req_ready), 32'h1);
        for (int k = 0; k < 8; k++) begin
            tick();
            check_eq("rr_gnt_valid", 32'(gnt_valid), 1);
            check_eq("rr_gnt_idx", 32'(gnt_idx), 32'(k % 4));
            check_eq("rr_ready", 32'(req_ready), 32'(1 << ((k + 1) % 4)));
        end
        exp_cnt = 4'd2;
        check_eq("rr_outst0", 32'(outst[0]), 32'(exp_cnt));

        // Weights {1,1,1,3}
        do_reset();
        weight    = {4'd1, 4'd1, 4'd1, 4'd3};
        req_write = 4'b1010;
        req_valid = 4'hF;
        for (int k = 0; k < 10; k++) begin
            tick();
            check_eq("wt_gnt_idx", 32'(gnt_idx), 32'(seq_idx[k]));
            check_eq("wt_gnt_write", 32'(gnt_write), 32'((4'b1010 >> seq_idx[k]) & 1));
        end

        // Credit limit
        do_reset();
        weight    = {4'd1, 4'd1, 4'd1, 4'd1};
        req_write = '0;
        max_outst = 4'd2;
        req_valid = 4'b0100;
        #1;
        check_eq("cl_ready_a", 32'(req_ready), 32'h4);
        tick();
        check_eq("cl_gnt1", 32'(gnt_idx), 2);
        check_eq("cl_ready_b", 32'(req_ready), 32'h4);
        tick();
        check_eq("cl_outst_full", 32'(outst[2]), 2);
        check_eq("cl_ready_blk", 32'(req_ready), 0);
        for (int k = 0; k < 3; k++) begin
            tick();
            check_eq("cl_gnt_empty", 32'(gnt_valid), 0);
            check_eq("cl_ready_held", 32'(req_ready), 0);
        end
        cpl_valid = 1'b1;
        cpl_idx   = 2'd2;
        #1;
        check_eq("cl_ready_cplcyc", 32'(req_ready), 0);
        tick();
        cpl_valid = 1'b0;
        #1;
        check_eq("cl_outst_freed", 32'(outst[2]), 1);
        check_eq("cl_ready_after", 32'(req_ready), 32'h4);
        tick();
        check_eq("cl_gnt_again", 32'(gnt_valid), 1);
        check_eq("cl_outst_refill", 32'(outst[2]), 2);
        check_eq("cl_ready_end", 32'(req_ready), 0);
        req_valid = '0;

        // Backpressure
        do_reset();
        max_outst = 4'd15;
        gnt_ready = 1'b0;
        req_valid = 4'hF;
        #1;
        check_eq("bp_ready_first", 32'(req_ready), 32'h1);
        tick();
        for (int k = 0; k < 5; k++) begin
            check_eq("bp_gnt_valid", 32'(gnt_valid), 1);
            check_eq("bp_gnt_idx", 32'(gnt_idx), 0);
            check_eq("bp_ready", 32'(req_ready), 0);
            check_eq("bp_outst", 32'(outst), 32'h0001);
            tick();
        end
        gnt_ready = 1'b1;
        #1;
        check_eq("bp_ready_resume", 32'(req_ready), 32'h2);
        for (int k = 1; k < 4; k++) begin
            tick();
            check_eq("bp_resume_idx", 32'(gnt_idx), 32'(k));
        end

        // Simultaneous inc/dec, then underflow
        do_reset();
        req_valid = 4'b0010;
        tick();
        check_eq("sid_outst_pre", 32'(outst[1]), 1);
        cpl_valid = 1'b1;
        cpl_idx   = 2'd1;
        #1;
        check_eq("sid_ready", 32'(req_ready), 32'h2);
        tick();
        check_eq("sid_outst_same", 32'(outst[1]), 1);
        check_eq("sid_err_clear", 32'(err), 0);
        req_valid = '0;
        cpl_idx   = 2'd3;
        tick();
        cpl_valid = 1'b0;
        check_eq("uf_outst3", 32'(outst[3]), 0);
        check_eq("uf_err_set", 32'(err), 1);
        repeat (2) tick();
        check_eq("uf_err_sticky", 32'(err), 1);

        // Mid-operation reset with a grant pending
        gnt_ready = 1'b0;
        req_valid = 4'hF;
        tick();
        check_eq("mr_pending", 32'(gnt_valid), 1);
        check_eq("mr_pending_idx", 32'(gnt_idx), 2);
        rst = 1'b1;
        #1;
        check_eq("mr_ready_in_rst", 32'(req_ready), 0);
        tick();
        check_eq("mr_gnt_valid", 32'(gnt_valid), 0);
        check_eq("mr_gnt_idx", 32'(gnt_idx), 0);
        check_eq("mr_gnt_write", 32'(gnt_write), 0);
        check_eq("mr_outst", 32'(outst), 0);
        check_eq("mr_err", 32'(err), 0);
        rst       = 1'b0;
        gnt_ready = 1'b1;
        #1;
        check_eq("mr_ready_first", 32'(req_ready), 32'h1);
        tick();
        check_eq("mr_first_idx", 32'(gnt_idx), 0);
        req_valid = '0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
